spike_filter_serializer: RTL
============================

// Module: spike_filter_serializer
// PURPOSE
// - Upstream end of the spike filter path: takes one SpikeFilterOutputChannel token (filt_idx, filt_state).
// - Emits two SerializedPCWordChannel words (code + NPCdata payload) toward the PC upstream arbiter.
// - Sits between the spike filter array and the upstream PC word funnel.
// - The PC-side deserializer reassembles each token from its LO/HI word pair.
// PARAMETERS
// - Nfilts   10       filter index width
// - Nstate   27       filter state width
// - NPCcode  7        PC word code width
// - NPCdata  20       PC word payload width
// - CODE_LO  7'd64    code of the first word (state low bits)
// - CODE_HI  7'd65    code of the second word (index + state high bits)
// - Elaboration check: Nfilts + (Nstate - NPCdata) <= NPCdata, Nstate > NPCdata; else $fatal.
// PORTS
// - clk                 in   1        system clock
// - reset               in   1        async reset, active-high
// - in.filt_idx         in   Nfilts   filter index (SpikeFilterOutputChannel)
// - in.filt_state       in   Nstate   filter state
// - in.v                in   1        input valid
// - in.a                out  1        input ack
// - out.code            out  NPCcode  PC word code (SerializedPCWordChannel)
// - out.payload         out  NPCdata  PC word payload
// - out.v               out  1        output valid
// - out.a               in   1        output ack
// BEHAVIOUR
// - Interface rules:
//   - One clock; reset is asynchronous and active-high.
//   - Transfer on any channel occurs in a cycle with v && a both high.
// - Reset values:
//   - state = IDLE; out.v = 0; out.code/out.payload = 0; captured registers = 0.
//   - in.a = 0 while reset is high.
// - FSM states: IDLE, SEND_LO, SEND_HI.
//   - IDLE: in.a = 1, out.v = 0. On in.v, capture idx/state -> SEND_LO.
//   - SEND_LO: out.v = 1, code = CODE_LO, payload = state[NPCdata-1:0]. On out.a -> SEND_HI.
//   - SEND_HI: out.v = 1, code = CODE_HI, payload = {zero pad, idx, state[Nstate-1:NPCdata]}.
//   - SEND_HI, in.a = out.a (combinational). out.a && in.v: capture new token -> SEND_LO; else out.a -> IDLE.
// - Latency and throughput:
//   - First word is valid the cycle after input capture.
//   - Steady state: 1 token per 2 cycles when out.a is held high.
// - Output stability: out.code/out.payload/out.v stay stable while out.v && !out.a (no retraction, no change).
// - in.a never depends on in.v; out.v never depends on out.a (no combinational loops).
// - Reset mid-word: any partially sent pair is discarded; the next token starts at LO. The PC side tolerates an orphan LO.
// CONFIGURATION
// - Macro SPIKE_FILT_SER_SKIP_ZERO_EN.
//   - Defined:
//     - A token with filt_state == 0 is acked in IDLE/SEND_HI as usual, but no words are emitted.
//     - The FSM goes to (or stays in) IDLE instead of SEND_LO.
//     - A 16-bit saturating counter zero_skipped (extra output port) increments per skipped token; reset value 0.
//   - Undefined:
//     - Every token produces a LO/HI pair; the zero_skipped port and counter are absent.
// STRUCTURE
// - Package pc_word_pkg:
//   - CODE_LO/CODE_HI localparams (the parameter defaults read from here).
//   - typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} ser_state_t.
//   - Function pack_hi(idx, state_hi) that returns the padded HI payload.
// - Single flat module; no sub-module is natural (FSM + capture regs + output mux only).
// TESTING
// 1. Single token:
//    - idx=3, state=27'h5A5A5A5, out.a=1.
//    - Expect word (64, 20'h5A5A5) then (65, 20'h001DA); in.a low during SEND_LO.
// 2. Back-to-back:
//    - 4 tokens with in.v held high, out.a=1.
//    - Expect 8 words on consecutive cycles, ordered LO,HI per token; total 8 cycles after first capture.
// 3. Backpressure:
//    - out.a=0 for 5 cycles during SEND_HI.
//    - Expect out word unchanged, in.a=0, no new capture.
//    - After out.a rises, the pending input is captured that same cycle.
// 4. Reset mid-pair:
//    - Assert reset in SEND_HI.
//    - Expect out.v=0 immediately (async), state IDLE.
//    - Next token idx=1, state=1 -> (64, 20'h00001), (65, 20'h00080).
// 5. Widths:
//    - idx=10'h3FF, state=27'h7FFFFFF.
//    - Expect payloads 20'hFFFFF and 20'h1FFFF; top 3 bits zero.
// 6. SPIKE_FILT_SER_SKIP_ZERO_EN:
//    - Tokens with state 0, 5, 0.
//    - Expect only the pair for state 5; zero_skipped=2.
//    - Without the macro: 3 pairs emitted.

Source files
------------

// File: rtl/pc_word_pkg.sv
// Shared PC word definitions for the spike filter upstream path: word codes,
// serializer FSM states, and HI-word payload packing.
package pc_word_pkg;

  localparam int NFILTS  = 10;
  localparam int NSTATE  = 27;
  localparam int NPCCODE = 7;
  localparam int NPCDATA = 20;

  localparam logic [NPCCODE-1:0] CODE_LO = 7'd64;
  localparam logic [NPCCODE-1:0] CODE_HI = 7'd65;

  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} ser_state_t;

  // HI payload: {zero pad, filter index, state bits above the LO word}
  function automatic logic [NPCDATA-1:0] pack_hi(input logic [NFILTS-1:0] idx,
                                                 input logic [NSTATE-NPCDATA-1:0] state_hi);
    return NPCDATA'({idx, state_hi});
  endfunction

endpackage

// File: rtl/spike_filter_serializer.sv
// Splits each spike filter token into a LO/HI PC word pair; registered outputs, 1 token per 2 cycles.
// Define SPIKE_FILT_SER_SKIP_ZERO_EN to drop zero-state tokens and count them on zero_skipped.
module spike_filter_serializer
  import pc_word_pkg::*;
#(
  parameter int                 Nfilts  = NFILTS,
  parameter int                 Nstate  = NSTATE,
  parameter int                 NPCcode = NPCCODE,
  parameter int                 NPCdata = NPCDATA,
  parameter logic [NPCcode-1:0] CODE_LO = NPCcode'(pc_word_pkg::CODE_LO),
  parameter logic [NPCcode-1:0] CODE_HI = NPCcode'(pc_word_pkg::CODE_HI)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [Nfilts-1:0]  in_filt_idx,
  input  logic [Nstate-1:0]  in_filt_state,
  input  logic               in_v,
  output logic               in_a,
  output logic [NPCcode-1:0] out_code,
  output logic [NPCdata-1:0] out_payload,
  output logic               out_v,
  input  logic               out_a
`ifdef SPIKE_FILT_SER_SKIP_ZERO_EN
  ,
  output logic [15:0]        zero_skipped
`endif
);

  localparam int SHI = Nstate - NPCdata;

  if ((Nfilts + SHI > NPCdata) || (Nstate <= NPCdata)) begin : g_bad_widths
    $fatal(1, "spike_filter_serializer: index and high state bits must fit one PC word");
  end

  ser_state_t        st;
  logic [Nfilts-1:0] idx_q;
  logic [SHI-1:0]    st_hi_q;
  logic              take;
  logic              skip;

  // Ready in IDLE, or in SEND_HI exactly when the HI word leaves this cycle
  assign in_a = !reset && ((st == IDLE) || ((st == SEND_HI) && out_a));
  assign take = in_v && in_a;

`ifdef SPIKE_FILT_SER_SKIP_ZERO_EN
  assign skip = (in_filt_state == '0);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= IDLE;
      out_v       <= 1'b0;
      out_code    <= '0;
      out_payload <= '0;
      idx_q       <= '0;
      st_hi_q     <= '0;
`ifdef SPIKE_FILT_SER_SKIP_ZERO_EN
      zero_skipped <= '0;
`endif
    end else if (take) begin
      idx_q   <= in_filt_idx;
      st_hi_q <= in_filt_state[Nstate-1:NPCdata];
      if (skip) begin
        st    <= IDLE;
        out_v <= 1'b0;
`ifdef SPIKE_FILT_SER_SKIP_ZERO_EN
        if (zero_skipped != 16'hFFFF) zero_skipped <= zero_skipped + 16'd1;
`endif
      end else begin
        st          <= SEND_LO;
        out_v       <= 1'b1;
        out_code    <= CODE_LO;
        out_payload <= in_filt_state[NPCdata-1:0];
      end
    end else if (out_a && (st == SEND_LO)) begin
      st          <= SEND_HI;
      out_code    <= CODE_HI;
      out_payload <= NPCdata'(pack_hi(NFILTS'(idx_q), (NSTATE-NPCDATA)'(st_hi_q)));
    end else if (out_a && (st == SEND_HI)) begin
      st    <= IDLE;
      out_v <= 1'b0;
    end
  end

endmodule
